cprv_mp_regfile: RTL

//  Multi-port integer register file with a per-register busy scoreboard and power-on scrub.

---
 rtl/cprv_regfile_pkg.sv | 8 +
 rtl/cprv_regfile_scoreboard.sv | 36 +++
 rtl/cprv_mp_regfile.sv | 101 ++++++++++
 3 files changed

// File: rtl/cprv_regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package cprv_regfile_pkg;

  typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

  localparam int ZERO_REG = 0;

endpackage

// File: rtl/cprv_regfile_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, one lookup per read port.
module cprv_regfile_scoreboard
  import cprv_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int MEM_DEPTH    = 2**ADDR_WIDTH,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     iss_set,
  input  logic [ADDR_WIDTH-1:0]                    iss_addr,
  input  logic                                     wr_clr,
  input  logic [ADDR_WIDTH-1:0]                    wr_addr,
  input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]  rs_addr,
  output logic [NUM_RD_PORTS-1:0]                  rs_busy
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [MEM_DEPTH-1:0] busy;

  // Issue has priority over writeback so a new producer keeps the register busy.
  for (genvar j = 0; j < MEM_DEPTH; j++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          busy[j] <= 1'b0;
      else if (iss_set && iss_addr == ADDR_WIDTH'(j))   busy[j] <= 1'b1;
      else if (wr_clr && wr_addr == ADDR_WIDTH'(j))     busy[j] <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_lkp
    assign rs_busy[i] = ({1'b0, rs_addr[i]} < DEPTH_C) ? busy[rs_addr[i]] : 1'b0;
  end

endmodule

// File: rtl/cprv_mp_regfile.sv
// Multi-port register file with busy scoreboard and power-on scrub.
// Define CPRV_REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module cprv_mp_regfile
  import cprv_regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int MEM_DEPTH    = 2**ADDR_WIDTH,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  output logic                                     init_done,
  input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]  rs_addr,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]  rs_data,
  output logic [NUM_RD_PORTS-1:0]                  rs_busy,
  input  logic                                     wr_en,
  input  logic [ADDR_WIDTH-1:0]                    wr_addr,
  input  logic [DATA_WIDTH-1:0]                    wr_data,
  input  logic                                     iss_en,
  input  logic [ADDR_WIDTH-1:0]                    iss_addr
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(MEM_DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_C  = ADDR_WIDTH'(ZERO_REG);

  rf_state_e              state, state_nxt;
  logic [ADDR_WIDTH-1:0]  idx;
  logic                   run;
  logic                   wr_ok, iss_ok;
  logic [NUM_RD_PORTS-1:0] sb_busy;
  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RF_INIT;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      RF_INIT: if (idx == LAST_C) state_nxt = RF_RUN;
      RF_RUN:  state_nxt = RF_RUN;
      default: state_nxt = RF_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run       = (state == RF_RUN);
    init_done = run;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  idx <= '0;
    else if (state == RF_INIT) idx <= idx + 1'b1;
  end

  // x0 and out-of-range destinations never reach storage or the scoreboard.
  assign wr_ok  = run && wr_en  && wr_addr  != ZERO_C && ({1'b0, wr_addr}  < DEPTH_C);
  assign iss_ok = run && iss_en && iss_addr != ZERO_C && ({1'b0, iss_addr} < DEPTH_C);

  // Storage has no reset; the INIT sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (!run)       mem[idx]     <= '0;
    else if (wr_ok) mem[wr_addr] <= wr_data;
  end

  cprv_regfile_scoreboard #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .MEM_DEPTH    (MEM_DEPTH),
    .NUM_RD_PORTS (NUM_RD_PORTS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_set  (iss_ok),
    .iss_addr (iss_addr),
    .wr_clr   (wr_ok),
    .wr_addr  (wr_addr),
    .rs_addr  (rs_addr),
    .rs_busy  (sb_busy)
  );

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
    logic rd_ok;
    assign rd_ok = run && rs_addr[i] != ZERO_C && ({1'b0, rs_addr[i]} < DEPTH_C);
`ifdef CPRV_REGFILE_BYPASS_EN
    logic rd_hit;
    assign rd_hit     = wr_ok && wr_addr == rs_addr[i];
    assign rs_data[i] = !rd_ok ? '0 : (rd_hit ? wr_data : mem[rs_addr[i]]);
    assign rs_busy[i] = rd_ok && !rd_hit && sb_busy[i];
`else
    assign rs_data[i] = rd_ok ? mem[rs_addr[i]] : '0;
    assign rs_busy[i] = rd_ok && sb_busy[i];
`endif
  end

endmodule
